// File: rtl/wb_primary_split.sv
// rtl/wb_primary_split.sv - Wishbone primary for core load/store requests, splits 64-bit accesses on a 32-bit bus.
module wb_primary_split #(
    parameter int DATA_SIZE      = 64,
    parameter int ADDR_SIZE      = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic                 req_wide,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [63:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [63:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [ADDR_SIZE-1:0] wb_addr,
    output logic [DATA_SIZE-1:0] wb_dat_o,
    input  logic [DATA_SIZE-1:0] wb_dat_i,
    input  logic                 wb_ack
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t         state, state_next;
    logic           two_beats;
    logic           we_q;
    logic [31:0]    wdata_hi;
    logic [WDW-1:0] wd;
    logic           in_beat;
    logic           accept;
    logic           wd_last;

    assign in_beat = (state == BEAT0) || (state == BEAT1);
    assign accept  = (state == IDLE) && req_valid && req_ready;
    assign wd_last = (wd == WD_LAST);

    // Bus strobes decode straight from state so an async reset drops them at once.
    assign wb_cyc    = in_beat;
    assign wb_stb    = in_beat;
    assign wb_we     = in_beat && we_q;
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = BEAT0;
            BEAT0: begin
                if (wb_ack)       state_next = two_beats ? BEAT1 : RESP;
                else if (wd_last) state_next = RESP;
            end
            BEAT1: if (wb_ack || wd_last) state_next = RESP;
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wb_addr   <= '0;
            wb_dat_o  <= '0;
            two_beats <= 1'b0;
            we_q      <= 1'b0;
            wdata_hi  <= '0;
            wd        <= '0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == IDLE);

            if (state_next != state) wd <= '0;
            else if (in_beat)        wd <= wd + WDW'(1);

            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q      <= req_we;
                        two_beats <= req_wide && (DATA_SIZE == 32);
                        wb_addr   <= req_addr;
                        wb_dat_o  <= req_wdata[DATA_SIZE-1:0];
                        wdata_hi  <= req_wdata[63:32];
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                BEAT0: begin
                    if (wb_ack) begin
                        if (!we_q) rsp_rdata[DATA_SIZE-1:0] <= wb_dat_i;
                        if (two_beats) begin
                            wb_addr  <= wb_addr + ADDR_SIZE'(4);
                            wb_dat_o <= DATA_SIZE'(wdata_hi);
                        end
                    end else if (wd_last) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                BEAT1: begin
                    if (wb_ack) begin
                        if (!we_q) rsp_rdata[63:32] <= wb_dat_i[31:0];
                    end else if (wd_last) begin
                        // Drop the low word already captured so a failed access reads as zero.
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_primary_split.sv
// tb/tb_wb_primary_split.sv - Directed bench for wb_primary_split on 32-bit and 64-bit buses.
module tb_wb_primary_split;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_we, req_wide;
    logic [63:0] req_addr, req_wdata;
    logic        v32, v64;

    logic        rdy32, rv32, re32, cyc32, stb32, we32, ack32;
    logic [63:0] rd32;
    logic [31:0] a32, do32, di32;

    logic        rdy64, rv64, re64, cyc64, stb64, we64, ack64;
    logic [63:0] rd64, a64, do64, di64;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] obs_addr [2];
    logic [31:0] obs_dat  [2];
    logic        obs_we   [2];
    int          nbeats, lat, rsp_cnt, cyc_cnt;
    logic [63:0] rsp_data;
    logic        rsp_e;

    always #5 clock = ~clock;

    wb_primary_split #(.DATA_SIZE(32), .ADDR_SIZE(32), .TIMEOUT_CYCLES(4)) dut32 (
        .clock(clock), .reset(reset), .req_valid(v32), .req_ready(rdy32),
        .req_we(req_we), .req_wide(req_wide), .req_addr(req_addr[31:0]), .req_wdata(req_wdata),
        .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_err(re32),
        .wb_cyc(cyc32), .wb_stb(stb32), .wb_we(we32), .wb_addr(a32),
        .wb_dat_o(do32), .wb_dat_i(di32), .wb_ack(ack32)
    );

    wb_primary_split #(.DATA_SIZE(64), .ADDR_SIZE(64), .TIMEOUT_CYCLES(8)) dut64 (
        .clock(clock), .reset(reset), .req_valid(v64), .req_ready(rdy64),
        .req_we(req_we), .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv64), .rsp_rdata(rd64), .rsp_err(re64),
        .wb_cyc(cyc64), .wb_stb(stb64), .wb_we(we64), .wb_addr(a64),
        .wb_dat_o(do64), .wb_dat_i(di64), .wb_ack(ack64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the 32-bit instance; the slave acks on the second cycle of each strobe.
    task automatic xact32(input logic we, input logic wide, input logic [31:0] addr,
                          input logic [63:0] wdata, input logic [31:0] d0, input logic [31:0] d1,
                          input logic ack_on);
        int cnt;
        int beat;
        cnt = 0; beat = 0; lat = 0; rsp_cnt = 0; cyc_cnt = 0;
        rsp_data = '0; rsp_e = 1'b0;
        for (int i = 0; i < 20 && !rdy32; i++) begin
            @(posedge clock); #1;
        end
        check("ready_before_req", rdy32, 1);
        req_we = we; req_wide = wide; req_addr = {32'h0, addr}; req_wdata = wdata;
        v32 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock); #1;
            if (k == 1) v32 = 1'b0;
            if (rv32) begin
                rsp_cnt++;
                if (lat == 0) lat = k;
                rsp_data = rd32;
                rsp_e = re32;
            end
            if (cyc32) cyc_cnt++;
            if (!cyc32) begin
                ack32 = 1'b0; cnt = 0;
            end else if (ack32) begin
                ack32 = 1'b0; cnt = 1;
            end else if (ack_on && cnt == 1) begin
                ack32 = 1'b1;
                di32 = (beat == 0) ? d0 : d1;
                if (beat < 2) begin
                    obs_addr[beat] = a32;
                    obs_dat[beat]  = do32;
                    obs_we[beat]   = we32;
                end
                beat++;
            end else begin
                cnt = 1;
            end
            if (lat != 0 && k > lat + 1) break;
        end
        nbeats = beat;
        ack32 = 1'b0;
    endtask

    initial begin
        int spur, gap, phase, pulses;
        logic cyc_at_resp;
        reset = 1'b1;
        v32 = 1'b0; v64 = 1'b0; ack32 = 1'b0; ack64 = 1'b0;
        di32 = '0; di64 = '0;
        req_we = 1'b0; req_wide = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", rdy32, 0);
        check("rst_rsp_valid", rv32, 0);
        check("rst_cyc", cyc32, 0);
        check("rst_addr", a32, 0);
        check("rst_dat_o", do32, 0);
        check("rst_rdata", rd32, 0);
        check("rst_err", re32, 0);
        check("rst_cyc64", cyc64, 0);
        reset = 1'b0;

        // Wide read split into two beats
        xact32(1'b0, 1'b1, 32'h0200_BFF8, 64'h0, 32'h1234_5678, 32'h0000_00AB, 1'b1);
        check("rd_nbeats", nbeats, 2);
        check("rd_addr0", obs_addr[0], 32'h0200_BFF8);
        check("rd_addr1", obs_addr[1], 32'h0200_BFFC);
        check("rd_we0", obs_we[0], 0);
        check("rd_data", rsp_data, 64'h0000_00AB_1234_5678);
        check("rd_err", rsp_e, 0);
        check("rd_lat", lat, 5);
        check("rd_rsp_cnt", rsp_cnt, 1);

        // Wide write
        xact32(1'b1, 1'b1, 32'h0200_4000, 64'hDEAD_BEEF_0000_0010, 32'h0, 32'h0, 1'b1);
        check("wr_nbeats", nbeats, 2);
        check("wr_dat0", obs_dat[0], 32'h0000_0010);
        check("wr_dat1", obs_dat[1], 32'hDEAD_BEEF);
        check("wr_we0", obs_we[0], 1);
        check("wr_we1", obs_we[1], 1);
        check("wr_rsp_cnt", rsp_cnt, 1);
        check("wr_rdata", rsp_data, 0);

        // Address wrap on the second beat
        xact32(1'b0, 1'b1, 32'hFFFF_FFFC, 64'h0, 32'h1111_1111, 32'h2222_2222, 1'b1);
        check("wrap_addr1", obs_addr[1], 32'h0000_0000);
        check("wrap_data", rsp_data, 64'h2222_2222_1111_1111);

        // Narrow read is zero-extended
        xact32(1'b0, 1'b0, 32'h0000_0100, 64'h0, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1);
        check("nr_nbeats", nbeats, 1);
        check("nr_data", rsp_data, 64'h0000_0000_CAFE_F00D);
        check("nr_lat", lat, 3);

        // Watchdog expiry in BEAT0
        xact32(1'b0, 1'b1, 32'h0200_BFF8, 64'h0, 32'h0, 32'h0, 1'b0);
        check("to_cyc_cycles", cyc_cnt, 4);
        check("to_err", rsp_e, 1);
        check("to_rdata", rsp_data, 0);
        check("to_lat", lat, 5);
        check("to_rsp_cnt", rsp_cnt, 1);

        xact32(1'b0, 1'b0, 32'h0000_0200, 64'h0, 32'h0000_5A5A, 32'h0, 1'b1);
        check("after_to_err", rsp_e, 0);
        check("after_to_data", rsp_data, 64'h0000_0000_0000_5A5A);

        // 64-bit bus: wide read is one beat, acked on the first bus cycle
        for (int i = 0; i < 20 && !rdy64; i++) begin
            @(posedge clock); #1;
        end
        req_we = 1'b0; req_wide = 1'b1; req_addr = 64'h0000_0000_0200_BFF8;
        v64 = 1'b1; lat = 0; nbeats = 0; cyc_at_resp = 1'b1; rsp_data = '0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            if (k == 1) v64 = 1'b0;
            if (rv64 && lat == 0) begin
                lat = k; rsp_data = rd64; cyc_at_resp = cyc64;
            end
            if (cyc64 && !ack64) begin
                ack64 = 1'b1; di64 = 64'h0123_4567_89AB_CDEF; nbeats++;
            end else begin
                ack64 = 1'b0;
            end
        end
        check("w64_nbeats", nbeats, 1);
        check("w64_lat", lat, 2);
        check("w64_cyc_in_resp", cyc_at_resp, 0);
        check("w64_data", rsp_data, 64'h0123_4567_89AB_CDEF);

        // Reset while in BEAT1
        for (int i = 0; i < 20 && !rdy32; i++) begin
            @(posedge clock); #1;
        end
        req_we = 1'b0; req_wide = 1'b1; req_addr = 64'h0000_0000_0200_0000;
        v32 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            if (k == 1) v32 = 1'b0;
            if (cyc32 && a32 == 32'h0200_0004) break;
            ack32 = cyc32 && !ack32;
        end
        ack32 = 1'b0;
        check("mid_beat1_addr", a32, 32'h0200_0004);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_cyc", cyc32, 0);
        check("mid_rst_stb", stb32, 0);
        check("mid_rst_rsp_valid", rv32, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        spur = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (rv32) spur++;
        end
        check("post_rst_spurious", spur, 0);
        check("post_rst_ready", rdy32, 1);

        // Back-to-back with req_valid held high
        req_we = 1'b0; req_wide = 1'b0; req_addr = 64'h0000_0000_0000_0300;
        di32 = 32'h0000_0077;
        v32 = 1'b1; gap = 0; phase = 0; pulses = 0;
        for (int k = 1; k <= 30 && pulses < 2; k++) begin
            @(posedge clock); #1;
            if (rv32) begin
                pulses++;
                check("b2b_ready_in_resp", rdy32, 0);
            end
            if (phase == 0 && cyc32) phase = 1;
            else if (phase == 1 && !cyc32) begin
                phase = 2; gap = 1;
            end else if (phase == 2 && !cyc32) gap++;
            else if (phase == 2 && cyc32) phase = 3;
            ack32 = cyc32 && !ack32;
        end
        v32 = 1'b0; ack32 = 1'b0;
        check("b2b_pulses", pulses, 2);
        check("b2b_second_cycle", phase, 3);
        check("b2b_gap", gap >= 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
